// File: rtl/alu_arb_pkg.sv
// Shared types and widths for the ALU arbiter: FSM states, opcode constants,
// operand/result widths and the watchdog counter width.
package alu_arb_pkg;

   localparam int OP_W   = 3;
   localparam int OPND_W = 8;
   localparam int RES_W  = 16;
   localparam int CNT_W  = 8;

   localparam logic [OP_W-1:0] OP_NOP = 3'b000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } arb_state_e;

endpackage

// File: rtl/alu_rr_pick.sv
// Combinational round-robin selector: first set request strictly after the
// pointer, wrapping around.
module alu_rr_pick #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = 2
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IDX_W-1:0]   ptr_i,
   output logic [IDX_W-1:0]   grant_o,
   output logic               any_req_o
);

   logic [IDX_W-1:0] cand;

   // Walk from the farthest candidate to the nearest so the nearest set bit wins.
   always_comb begin
      grant_o   = '0;
      any_req_o = 1'b0;
      cand      = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         cand = IDX_W'((int'(ptr_i) + k) % NUM_REQ);
         if (req_i[cand]) begin
            grant_o   = cand;
            any_req_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between NUM_REQ requesters with round-robin grant, local NOP
// completion and a per-operation watchdog. All outputs are registered.
//
// state | meaning
// IDLE  | waiting for any request; picks the next requester round-robin
// BUSY  | ALU op in flight, alu_start held, watchdog counting down
// RESP  | one-cycle response pulse to the granted requester
module alu_arbiter
   import alu_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int TIMEOUT = 16
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [OP_W*NUM_REQ-1:0]   req_op,
   input  logic [OPND_W*NUM_REQ-1:0] req_a,
   input  logic [OPND_W*NUM_REQ-1:0] req_b,
   output logic [NUM_REQ-1:0]        rsp_valid,
   output logic [RES_W-1:0]          rsp_result,
   output logic                      rsp_error,
   output logic                      alu_start,
   output logic [OP_W-1:0]           alu_op,
   output logic [OPND_W-1:0]         alu_a,
   output logic [OPND_W-1:0]         alu_b,
   input  logic                      alu_done,
   input  logic [RES_W-1:0]          alu_result,
   output logic                      busy,
   output logic [CNT_W-1:0]          timeout_count
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [CNT_W-1:0] TMO_LOAD = CNT_W'(TIMEOUT - 1);

   arb_state_e          state_q, state_d;
   logic [IDX_W-1:0]    idx_q, idx_d, ptr_q, ptr_d;
   logic [OP_W-1:0]     op_q, op_d;
   logic [OPND_W-1:0]   a_q, a_d, b_q, b_d;
   logic                start_q, start_d;
   logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
   logic [RES_W-1:0]    rsp_result_q, rsp_result_d;
   logic                rsp_error_q, rsp_error_d;
   logic                busy_q;
   logic [CNT_W-1:0]    tmo_cnt_q, tmo_cnt_d;
   logic [CNT_W-1:0]    timer_q, timer_d;

   logic [IDX_W-1:0]    grant_idx;
   logic                any_req;
   logic [OP_W-1:0]     op_arr [NUM_REQ];
   logic [OPND_W-1:0]   a_arr  [NUM_REQ];
   logic [OPND_W-1:0]   b_arr  [NUM_REQ];

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign op_arr[g] = req_op[OP_W*g +: OP_W];
      assign a_arr[g]  = req_a[OPND_W*g +: OPND_W];
      assign b_arr[g]  = req_b[OPND_W*g +: OPND_W];
   end

   alu_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_pick (
      .req_i     (req_valid),
      .ptr_i     (ptr_q),
      .grant_o   (grant_idx),
      .any_req_o (any_req)
   );

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      ptr_d        = ptr_q;
      op_d         = op_q;
      a_d          = a_q;
      b_d          = b_q;
      start_d      = start_q;
      rsp_valid_d  = '0;
      rsp_result_d = rsp_result_q;
      rsp_error_d  = rsp_error_q;
      tmo_cnt_d    = tmo_cnt_q;
      timer_d      = timer_q;
      case (state_q)
         IDLE: begin
            if (any_req) begin
               idx_d = grant_idx;
               if (op_arr[grant_idx] == OP_NOP) begin
                  state_d                = RESP;
                  rsp_valid_d[grant_idx] = 1'b1;
                  rsp_result_d           = '0;
                  rsp_error_d            = 1'b0;
               end else begin
                  state_d = BUSY;
                  start_d = 1'b1;
                  op_d    = op_arr[grant_idx];
                  a_d     = a_arr[grant_idx];
                  b_d     = b_arr[grant_idx];
                  timer_d = TMO_LOAD;
               end
            end
         end
         BUSY: begin
            // A done arriving in the last allowed cycle still counts as success.
            if (alu_done) begin
               state_d            = RESP;
               start_d            = 1'b0;
               rsp_valid_d[idx_q] = 1'b1;
               rsp_result_d       = alu_result;
               rsp_error_d        = 1'b0;
            end else if (timer_q == '0) begin
               state_d            = RESP;
               start_d            = 1'b0;
               rsp_valid_d[idx_q] = 1'b1;
               rsp_result_d       = '0;
               rsp_error_d        = 1'b1;
               if (tmo_cnt_q != '1) tmo_cnt_d = tmo_cnt_q + 1'b1;
            end else begin
               timer_d = timer_q - 1'b1;
            end
         end
         RESP: begin
            ptr_d   = idx_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         idx_q        <= '0;
         ptr_q        <= IDX_W'(NUM_REQ - 1);
         op_q         <= '0;
         a_q          <= '0;
         b_q          <= '0;
         start_q      <= 1'b0;
         rsp_valid_q  <= '0;
         rsp_result_q <= '0;
         rsp_error_q  <= 1'b0;
         busy_q       <= 1'b0;
         tmo_cnt_q    <= '0;
         timer_q      <= '0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         ptr_q        <= ptr_d;
         op_q         <= op_d;
         a_q          <= a_d;
         b_q          <= b_d;
         start_q      <= start_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_result_q <= rsp_result_d;
         rsp_error_q  <= rsp_error_d;
         busy_q       <= (state_d != IDLE);
         tmo_cnt_q    <= tmo_cnt_d;
         timer_q      <= timer_d;
      end
   end

   assign rsp_valid     = rsp_valid_q;
   assign rsp_result    = rsp_result_q;
   assign rsp_error     = rsp_error_q;
   assign alu_start     = start_q;
   assign alu_op        = op_q;
   assign alu_a         = a_q;
   assign alu_b         = b_q;
   assign busy          = busy_q;
   assign timeout_count = tmo_cnt_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: ALU model plus a transaction-level round-robin and
// watchdog reference, directed cases followed by randomized traffic.
module tb_alu_arbiter;

   localparam int NR  = 4;
   localparam int TMO = 8;

   logic            clk = 1'b0;
   logic            reset_n = 1'b0;
   logic [NR-1:0]   req_valid = '0;
   logic [3*NR-1:0] req_op = '0;
   logic [8*NR-1:0] req_a = '0;
   logic [8*NR-1:0] req_b = '0;
   logic [NR-1:0]   rsp_valid;
   logic [15:0]     rsp_result;
   logic            rsp_error;
   logic            alu_start;
   logic [2:0]      alu_op;
   logic [7:0]      alu_a, alu_b;
   logic            alu_done = 1'b0;
   logic [15:0]     alu_result = '0;
   logic            busy;
   logic [7:0]      timeout_count;

   alu_arbiter #(.NUM_REQ(NR), .TIMEOUT(TMO)) dut (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid), .req_op(req_op), .req_a(req_a), .req_b(req_b),
      .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_error(rsp_error),
      .alu_start(alu_start), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
      .alu_done(alu_done), .alu_result(alu_result),
      .busy(busy), .timeout_count(timeout_count)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   logic [2:0] op_r [NR];
   logic [7:0] a_r  [NR];
   logic [7:0] b_r  [NR];
   int         cool [NR];

   // reference model state
   int          last_ptr = NR - 1;
   int          tmo_model = 0;
   int          cur_exp = 0, cur_lat = 0, start_len = 0, acnt = 0;
   logic [15:0] cur_res = '0;
   logic        prev_start = 1'b0;
   int          lat_fixed = 0;
   logic        res_force = 1'b0;
   logic [15:0] res_val = '0;
   logic        rand_mode = 1'b0;
   logic        rsp_seen = 1'b0;
   logic [NR-1:0] rsp_vec = '0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int rr_pick(input logic [NR-1:0] req, input int last);
      for (int k = 1; k <= NR; k++) begin
         int c;
         c = (last + k) % NR;
         if (req[c]) return c;
      end
      return -1;
   endfunction

   function automatic logic [15:0] res_fn(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      if (res_force) return res_val;
      return (op == 3'd1) ? 16'(a) + 16'(b) : 16'(a) * 16'(b);
   endfunction

   task automatic drive_ops();
      for (int i = 0; i < NR; i++) begin
         req_op[3*i +: 3] = op_r[i];
         req_a[8*i +: 8]  = a_r[i];
         req_b[8*i +: 8]  = b_r[i];
      end
   endtask

   task automatic set_req(input int i, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      op_r[i] = op; a_r[i] = a; b_r[i] = b;
      req_valid[i] = 1'b1;
      drive_ops();
   endtask

   task automatic model_reset();
      last_ptr = NR - 1; tmo_model = 0; prev_start = 1'b0;
      start_len = 0; acnt = 0; alu_done = 1'b0;
   endtask

   // one clock: observe at the falling edge, then update ALU model and requesters
   task automatic step();
      int  e;
      logic via, exp_via, err_e;
      logic [15:0] res_e;
      @(negedge clk);
      rsp_seen = 1'b0;
      if (rsp_valid != '0) begin
         rsp_seen = 1'b1;
         rsp_vec  = rsp_valid;
         via = prev_start;
         e = via ? cur_exp : rr_pick(req_valid, last_ptr);
         if (e < 0) begin
            check_eq("rsp_spurious", 32'(rsp_valid), 0);
         end else begin
            exp_via = (op_r[e] != 3'd0);
            check_eq("rsp_path", 32'(via), 32'(exp_via));
            check_eq("rsp_onehot", 32'(rsp_valid), 32'd1 << e);
            if (via) begin
               err_e = (cur_lat > TMO);
               res_e = err_e ? 16'h0 : cur_res;
               check_eq("start_len", start_len, err_e ? TMO : cur_lat);
               if (err_e && tmo_model < 255) tmo_model++;
            end else begin
               err_e = 1'b0;
               res_e = 16'h0;
            end
            check_eq("rsp_result", 32'(rsp_result), 32'(res_e));
            check_eq("rsp_error", 32'(rsp_error), 32'(err_e));
            check_eq("tmo_cnt", 32'(timeout_count), tmo_model);
            check_eq("busy_resp", 32'(busy), 1);
            last_ptr = e;
         end
         for (int i = 0; i < NR; i++) if (rsp_valid[i]) cool[i] = 2;
         req_valid = req_valid & ~rsp_valid;
      end
      if (alu_start && !prev_start) begin
         e = rr_pick(req_valid, last_ptr);
         check_eq("grant_any", 32'(e >= 0), 1);
         if (e >= 0) begin
            cur_exp = e;
            check_eq("grant_op", 32'(alu_op), 32'(op_r[e]));
            check_eq("grant_a", 32'(alu_a), 32'(a_r[e]));
            check_eq("grant_b", 32'(alu_b), 32'(b_r[e]));
            check_eq("alu_op_nonnop", 32'(alu_op != 3'd0), 1);
            cur_lat = (lat_fixed != 0) ? lat_fixed : int'($urandom_range(1, 10));
            cur_res = res_fn(op_r[e], a_r[e], b_r[e]);
         end
         start_len = 1; acnt = 0;
      end else if (alu_start) begin
         start_len++;
      end
      if (alu_start) begin
         acnt++;
         alu_done   = (acnt == cur_lat);
         alu_result = alu_done ? cur_res : 16'($urandom);
      end else begin
         alu_done   = 1'b0;
         alu_result = 16'($urandom);
      end
      prev_start = alu_start;
      if (rand_mode) begin
         for (int i = 0; i < NR; i++) begin
            if (cool[i] > 0) cool[i]--;
            else if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
               op_r[i] = ($urandom_range(0, 4) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
               a_r[i]  = 8'($urandom);
               b_r[i]  = 8'($urandom);
               req_valid[i] = 1'b1;
            end
         end
         drive_ops();
      end
   endtask

   task automatic wait_rsp(output int idx, output int ncyc);
      idx = -1; ncyc = 0;
      for (int n = 0; n < 40; n++) begin
         step();
         ncyc++;
         if (rsp_seen) break;
      end
      check_eq("rsp_arrived", 32'(rsp_seen), 1);
      for (int i = 0; i < NR; i++) if (rsp_seen && rsp_vec[i]) idx = i;
   endtask

   task automatic drain();
      for (int n = 0; n < 400 && req_valid != '0; n++) step();
      check_eq("drain", 32'(req_valid), 0);
   endtask

   int idx, nc;
   int order [5];
   int exp_order [5] = '{0, 1, 2, 3, 0};

   initial begin
      for (int i = 0; i < NR; i++) begin op_r[i] = 3'd1; a_r[i] = '0; b_r[i] = '0; cool[i] = 0; end
      drive_ops();
      repeat (3) step();
      check_eq("rst_start", 32'(alu_start), 0);
      check_eq("rst_rsp_valid", 32'(rsp_valid), 0);
      check_eq("rst_rsp_error", 32'(rsp_error), 0);
      check_eq("rst_busy", 32'(busy), 0);
      check_eq("rst_alu_bus", 32'({alu_op, alu_a, alu_b}), 0);
      check_eq("rst_rsp_result", 32'(rsp_result), 0);
      check_eq("rst_tmo", 32'(timeout_count), 0);
      reset_n = 1'b1;
      step();

      // single request, 3-cycle ALU
      lat_fixed = 3;
      set_req(0, 3'b001, 8'h05, 8'h03);
      wait_rsp(idx, nc);
      check_eq("single_idx", idx, 0);
      check_eq("single_res", 32'(rsp_result), 32'h0008);
      check_eq("single_len", start_len, 3);
      step(); step();

      // NOP completes locally
      set_req(2, 3'b000, 8'hAA, 8'h55);
      wait_rsp(idx, nc);
      check_eq("nop_idx", idx, 2);
      check_eq("nop_rsp_delay", nc, 1);
      step(); step();

      // timeout; requester drops req_valid after grant
      lat_fixed = 255;
      set_req(1, 3'b010, 8'h12, 8'h34);
      step(); step(); step();
      req_valid[1] = 1'b0;
      wait_rsp(idx, nc);
      check_eq("tmo_idx", idx, 1);
      check_eq("tmo_error", 32'(rsp_error), 1);
      check_eq("tmo_count1", 32'(timeout_count), 1);
      step(); step();
      lat_fixed = 2;
      set_req(1, 3'b001, 8'h20, 8'h22);
      wait_rsp(idx, nc);
      check_eq("after_tmo_err", 32'(rsp_error), 0);
      step(); step();

      // done on the last allowed cycle
      lat_fixed = TMO; res_force = 1'b1; res_val = 16'h00FF;
      set_req(3, 3'b011, 8'h0F, 8'h11);
      wait_rsp(idx, nc);
      check_eq("bnd_error", 32'(rsp_error), 0);
      check_eq("bnd_result", 32'(rsp_result), 32'h00FF);
      check_eq("bnd_tmo", 32'(timeout_count), 1);
      res_force = 1'b0;
      step(); step();

      // contention with re-request
      lat_fixed = 4;
      for (int i = 0; i < NR; i++) set_req(i, 3'(i + 1), 8'(16 * i + 1), 8'(16 * i + 2));
      for (int n = 0; n < 5; n++) begin
         wait_rsp(idx, nc);
         order[n] = idx;
         step(); step();
         if (n < 4 && idx >= 0) req_valid[idx] = 1'b1;
      end
      for (int n = 0; n < 5; n++) check_eq("rr_order", order[n], exp_order[n]);
      drain();

      // randomized traffic
      lat_fixed = 0;
      rand_mode = 1'b1;
      repeat (800) step();
      rand_mode = 1'b0;
      drain();
      step(); step();

      // asynchronous reset in the middle of an op
      lat_fixed = 255;
      set_req(0, 3'b001, 8'h01, 8'h02);
      for (int n = 0; n < 5 && !alu_start; n++) step();
      check_eq("mid_start", 32'(alu_start), 1);
      step(); step();
      #2 reset_n = 1'b0;
      #1;
      check_eq("rst_async_start", 32'(alu_start), 0);
      check_eq("rst_async_busy", 32'(busy), 0);
      req_valid = '0;
      model_reset();
      step();
      check_eq("rst_no_rsp", 32'(rsp_valid), 0);
      reset_n = 1'b1;
      lat_fixed = 2;
      set_req(1, 3'b001, 8'h07, 8'h08);
      set_req(0, 3'b010, 8'h03, 8'h04);
      wait_rsp(idx, nc);
      check_eq("post_rst_first", idx, 0);
      wait_rsp(idx, nc);
      check_eq("post_rst_second", idx, 1);
      step(); step();

      // saturate the timeout counter
      lat_fixed = 255;
      for (int n = 0; n < 300 && tmo_model < 255; n++) begin
         set_req(0, 3'b001, 8'h01, 8'h01);
         wait_rsp(idx, nc);
         step(); step();
      end
      set_req(0, 3'b001, 8'h01, 8'h01);
      wait_rsp(idx, nc);
      check_eq("tmo_sat", 32'(timeout_count), 255);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
